// File: rtl/key_debounce_pkg.sv
// Shared state encodings and default timing for the key-input blocks
// (debouncer today, display/counter key logic later).
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } key_state_e;

  // Defaults assume a 50 MHz clock: 20 ms debounce, 1 s to first repeat, 200 ms repeat.
  localparam int KEY_W_DEF       = 3;
  localparam int TIME_20MS_DEF   = 1_000_000;
  localparam int TIME_LONG_DEF   = 50_000_000;
  localparam int TIME_REPEAT_DEF = 10_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and hold/repeat timers.
// Key line and key_level are active-low; all outputs come straight from flops.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int TIME_20MS   = TIME_20MS_DEF,
  parameter int TIME_LONG   = TIME_LONG_DEF,
  parameter int TIME_REPEAT = TIME_REPEAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int DW = $clog2(TIME_20MS);
  localparam int HW = $clog2(TIME_LONG);
  localparam int RW = $clog2(TIME_REPEAT);

  localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(TIME_20MS - 1);
  localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_PRE  = HW'(TIME_LONG - 2);
  localparam logic [HW-1:0] H_LAST = HW'(TIME_LONG - 1);
  localparam logic [RW-1:0] R_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(TIME_REPEAT - 1);

  logic       s1_r;
  logic       s2_r;
  key_state_e state_r;
  logic [DW-1:0] dcnt_r;
  logic [HW-1:0] hcnt_r;
  logic [RW-1:0] rcnt_r;
  logic       hold_run_s;

  // Metastability guard on the asynchronous key line; idles released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= key_in;
      s2_r <= s1_r;
    end
  end

  // A cycle counts toward hold time whenever a confirmed-held key is seen low,
  // including the cycle a release glitch is rejected, so a glitch of N cycles
  // delays the repeat schedule by exactly N.
  always_comb begin
    hold_run_s = 1'b0;
    if (!s2_r && ((state_r == ST_HELD) || (state_r == ST_REL_DB))) begin
      hold_run_s = 1'b1;
    end else begin
      hold_run_s = 1'b0;
    end
  end

  // Debounce FSM with hold/repeat timers and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dcnt_r      <= D_ZERO;
      hcnt_r      <= H_ZERO;
      rcnt_r      <= R_ZERO;
      key_level   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;

      if (hold_run_s) begin
        if (hcnt_r != H_LAST) begin
          hcnt_r <= hcnt_r + H_ONE;
          if (hcnt_r == H_PRE) begin
            key_repeat <= 1'b1;
          end
        end else if (rcnt_r == R_LAST) begin
          rcnt_r     <= R_ZERO;
          key_repeat <= 1'b1;
        end else begin
          rcnt_r <= rcnt_r + R_ONE;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (!s2_r) begin
            state_r <= ST_PRESS_DB;
            dcnt_r  <= D_ZERO;
          end
        end
        ST_PRESS_DB: begin
          if (s2_r) begin
            state_r <= ST_IDLE;
            dcnt_r  <= D_ZERO;
          end else if (dcnt_r == D_LAST) begin
            state_r   <= ST_HELD;
            key_press <= 1'b1;
            key_level <= 1'b0;
            hcnt_r    <= H_ZERO;
            rcnt_r    <= R_ZERO;
          end else begin
            dcnt_r <= dcnt_r + D_ONE;
          end
        end
        ST_HELD: begin
          if (s2_r) begin
            state_r <= ST_REL_DB;
            dcnt_r  <= D_ZERO;
          end
        end
        ST_REL_DB: begin
          if (!s2_r) begin
            state_r <= ST_HELD;
          end else if (dcnt_r == D_LAST) begin
            state_r     <= ST_IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b1;
            hcnt_r      <= H_ZERO;
            rcnt_r      <= R_ZERO;
          end else begin
            dcnt_r <= dcnt_r + D_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          dcnt_r  <= D_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: KEY_W independent channels packed into per-key vectors
// of level, press, release and auto-repeat.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int TIME_20MS   = TIME_20MS_DEF,
  parameter int TIME_LONG   = TIME_LONG_DEF,
  parameter int TIME_REPEAT = TIME_REPEAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_repeat
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .TIME_20MS   (TIME_20MS),
      .TIME_LONG   (TIME_LONG),
      .TIME_REPEAT (TIME_REPEAT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts
// events per clock edge; a negedge monitor pops and compares them.
module tb_key_debounce;

  localparam int KEY_W = 3;
  localparam int T20   = 8;
  localparam int TL    = 40;
  localparam int TR    = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [KEY_W-1:0] key_in = 3'b111;
  logic [KEY_W-1:0] key_level;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
  logic [KEY_W-1:0] key_repeat;

  always #5 clk = ~clk;

  key_debounce #(
    .KEY_W       (KEY_W),
    .TIME_20MS   (T20),
    .TIME_LONG   (TL),
    .TIME_REPEAT (TR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  typedef struct {
    int               cyc;
    logic [KEY_W-1:0] press;
    logic [KEY_W-1:0] rls;
    logic [KEY_W-1:0] rep;
  } ev_t;

  ev_t              exp_q[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  logic [KEY_W-1:0] mdl_level = 3'b111;

  int               press_cyc [KEY_W];
  int               first_rep [KEY_W];
  int               last_rep  [KEY_W];
  int               press_cnt [KEY_W];
  int               rel_cnt   [KEY_W];
  int               rep_cnt   [KEY_W];
  int               rel_cyc   [KEY_W];
  logic [KEY_W-1:0] last_press_vec = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: a key's level flips once the synchronised line has shown the
  // opposite value for T20+1 consecutive edges; held low-samples after a press
  // give a repeat at count TL-1 and every TR counts after that.
  initial begin : model
    logic [KEY_W-1:0] d1, d2, seen;
    int run  [KEY_W];
    int held [KEY_W];
    ev_t e;
    d1 = 3'b111;
    d2 = 3'b111;
    for (int c = 0; c < KEY_W; c++) begin
      run[c]  = 0;
      held[c] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mdl_level = 3'b111;
        d1 = 3'b111;
        d2 = 3'b111;
        for (int c = 0; c < KEY_W; c++) begin
          run[c]  = 0;
          held[c] = 0;
        end
      end else begin
        seen = d2;
        d2 = d1;
        d1 = key_in;
        e.cyc = cyc;
        e.press = 3'b000;
        e.rls = 3'b000;
        e.rep = 3'b000;
        for (int c = 0; c < KEY_W; c++) begin
          if (seen[c] != mdl_level[c]) run[c]++;
          else run[c] = 0;
          if (run[c] == T20 + 1) begin
            run[c] = 0;
            held[c] = 0;
            mdl_level[c] = seen[c];
            if (seen[c] == 1'b0) e.press[c] = 1'b1;
            else e.rls[c] = 1'b1;
          end else if (mdl_level[c] == 1'b0 && seen[c] == 1'b0) begin
            held[c]++;
            if (held[c] == TL - 1 || (held[c] > TL - 1 && (held[c] - (TL - 1)) % TR == 0))
              e.rep[c] = 1'b1;
          end
        end
        if ((e.press | e.rls | e.rep) != 3'b000) exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard and logs event times.
  initial begin : monitor
    ev_t e;
    logic [KEY_W-1:0] pr, rl, rp, bad;
    for (int c = 0; c < KEY_W; c++) begin
      press_cyc[c] = -1000;
      first_rep[c] = -1;
      last_rep[c]  = -1;
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      rep_cnt[c]   = 0;
      rel_cyc[c]   = -1000;
    end
    forever begin
      @(negedge clk);
      pr = key_press;
      rl = key_release;
      rp = key_repeat;
      if (!rst_n) begin
        check("reset_level", 32'(key_level), 32'(3'b111));
        check("reset_pulses", 32'({pr, rl, rp}), 32'd0);
        exp_q.delete();
      end else begin
        check("level", 32'(key_level), 32'(mdl_level));
        bad = (pr & rl) | (pr & rp) | (rl & rp);
        check("pulse_exclusive", 32'(bad), 32'd0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          check("event_missing_cycle", 32'(exp_q[0].cyc), 32'(cyc));
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
        end else begin
          e.cyc = cyc;
          e.press = 3'b000;
          e.rls = 3'b000;
          e.rep = 3'b000;
        end
        if ((pr | rl | rp) != 3'b000 || (e.press | e.rls | e.rep) != 3'b000) begin
          check("press_vec", 32'(pr), 32'(e.press));
          check("release_vec", 32'(rl), 32'(e.rls));
          check("repeat_vec", 32'(rp), 32'(e.rep));
        end
        if (pr != 3'b000) last_press_vec = pr;
        for (int c = 0; c < KEY_W; c++) begin
          if (pr[c]) begin
            press_cnt[c]++;
            press_cyc[c] = cyc;
            first_rep[c] = -1;
          end
          if (rl[c]) begin
            rel_cnt[c]++;
            rel_cyc[c] = cyc;
          end
          if (rp[c]) begin
            rep_cnt[c]++;
            last_rep[c] = cyc;
            if (first_rep[c] < 0) first_rep[c] = cyc;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int k, p, r0, r1, rl0, rl_sum;

    // Reset with every key pressed
    rst_n = 1'b0;
    key_in = 3'b000;
    tick(6);
    check("rst_level_direct", 32'(key_level), 32'(3'b111));
    rst_n = 1'b1;
    tick(20);
    key_in = 3'b111;
    tick(20);

    // Clean press on key 0
    key_in[0] = 1'b0;
    k = cyc;
    tick(20);
    check("press_latency", 32'(press_cyc[0] - k), 32'd11);
    check("press_only_key0", 32'(last_press_vec), 32'(3'b001));
    check("level_key0_low", 32'(key_level[0]), 32'd0);

    // Bounce on key 1 must be rejected
    r0 = press_cnt[1];
    key_in[1] = 1'b0; tick(5);
    key_in[1] = 1'b1; tick(2);
    key_in[1] = 1'b0; tick(5);
    key_in[1] = 1'b1; tick(20);
    check("bounce_no_press", 32'(press_cnt[1] - r0), 32'd0);
    check("bounce_level_high", 32'(key_level[1]), 32'd1);

    // Long hold on key 2, then a 3-cycle release glitch
    key_in[2] = 1'b0;
    k = cyc;
    p = k + 11;
    tick(11);
    r0 = rep_cnt[2];
    tick(100);
    check("repeat_count_100", 32'(rep_cnt[2] - r0), 32'd7);
    check("first_repeat_offset", 32'(first_rep[2] - p), 32'd39);
    tick(2);
    rl0 = rel_cnt[2];
    key_in[2] = 1'b1; tick(3);
    key_in[2] = 1'b0;
    r1 = rep_cnt[2];
    tick(10);
    check("glitch_no_release", 32'(rel_cnt[2] - rl0), 32'd0);
    check("glitch_repeat_count", 32'(rep_cnt[2] - r1), 32'd1);
    check("glitch_repeat_shift", 32'(last_rep[2] - p), 32'd112);
    key_in[2] = 1'b1;
    tick(15);

    // Release key 0, then re-press for a fresh hold count
    key_in[0] = 1'b1;
    k = cyc;
    tick(20);
    check("release_latency", 32'(rel_cyc[0] - k), 32'd11);
    check("level_key0_high", 32'(key_level[0]), 32'd1);
    key_in[0] = 1'b0;
    k = cyc;
    tick(60);
    check("repress_first_repeat", 32'(first_rep[0] - (k + 11)), 32'd39);
    key_in[0] = 1'b1;
    tick(20);

    // Keys 0 and 2 together, then reset while held
    key_in = 3'b010;
    k = cyc;
    tick(15);
    check("dual_press_vec", 32'(last_press_vec), 32'(3'b101));
    check("dual_press_latency", 32'(press_cyc[2] - k), 32'd11);
    tick(5);
    rl_sum = rel_cnt[0] + rel_cnt[1] + rel_cnt[2];
    rst_n = 1'b0;
    tick(1);
    check("midhold_rst_level", 32'(key_level), 32'(3'b111));
    check("midhold_rst_pulses", 32'({key_press, key_release, key_repeat}), 32'd0);
    key_in = 3'b111;
    tick(4);
    rst_n = 1'b1;
    tick(30);
    check("rst_no_release", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] - rl_sum), 32'd0);

    // Randomised bounce/hold traffic with occasional resets
    for (int it = 0; it < 60; it++) begin
      key_in = 3'($urandom);
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(40, 90)));
      else tick(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    end

    key_in = 3'b111;
    tick(40);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
